// File: rtl/sc_game_pkg.sv
// Shared definitions for the Frogger game controller: state encodings and
// active-low signalling levels used by the controller and its datapath neighbours.
package sc_game_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_HIT       = 3'd3,
        ST_GOAL      = 3'd4,
        ST_RESPAWN   = 3'd5,
        ST_GAME_OVER = 3'd6,
        ST_WIN       = 3'd7
    } gameState_t;

    localparam logic ACTIVE_LOW_ON  = 1'b0;
    localparam logic ACTIVE_LOW_OFF = 1'b1;

endpackage

// File: rtl/sc_game_controller_if.sv
// Signal bundle between the game controller and the detectors/datapaths around it.
// master = surrounding logic (drives button and detectors), slave = controller.
interface sc_game_controller_if #(
    parameter int LIVES_W = 2,
    parameter int LEVEL_W = 2
);
    logic               SC_STATEMACHINEGENERAL_startButton_InLow;
    logic               SC_STATEMACHINEGENERAL_Losing_InLow;
    logic               SC_STATEMACHINEGENERAL_Goal_InLow;
    logic               SC_STATEMACHINEGENERAL_clear_OutLow;
    logic               SC_STATEMACHINEGENERAL_frogReset_OutLow;
    logic               SC_STATEMACHINEGENERAL_levelUp_OutHigh;
    logic               SC_STATEMACHINEGENERAL_playing_OutHigh;
    logic               SC_STATEMACHINEGENERAL_gameOver_OutHigh;
    logic               SC_STATEMACHINEGENERAL_win_OutHigh;
    logic [LIVES_W-1:0] SC_STATEMACHINEGENERAL_lives_Out;
    logic [LEVEL_W-1:0] SC_STATEMACHINEGENERAL_level_Out;

    modport master (
        output SC_STATEMACHINEGENERAL_startButton_InLow,
        output SC_STATEMACHINEGENERAL_Losing_InLow,
        output SC_STATEMACHINEGENERAL_Goal_InLow,
        input  SC_STATEMACHINEGENERAL_clear_OutLow,
        input  SC_STATEMACHINEGENERAL_frogReset_OutLow,
        input  SC_STATEMACHINEGENERAL_levelUp_OutHigh,
        input  SC_STATEMACHINEGENERAL_playing_OutHigh,
        input  SC_STATEMACHINEGENERAL_gameOver_OutHigh,
        input  SC_STATEMACHINEGENERAL_win_OutHigh,
        input  SC_STATEMACHINEGENERAL_lives_Out,
        input  SC_STATEMACHINEGENERAL_level_Out
    );

    modport slave (
        input  SC_STATEMACHINEGENERAL_startButton_InLow,
        input  SC_STATEMACHINEGENERAL_Losing_InLow,
        input  SC_STATEMACHINEGENERAL_Goal_InLow,
        output SC_STATEMACHINEGENERAL_clear_OutLow,
        output SC_STATEMACHINEGENERAL_frogReset_OutLow,
        output SC_STATEMACHINEGENERAL_levelUp_OutHigh,
        output SC_STATEMACHINEGENERAL_playing_OutHigh,
        output SC_STATEMACHINEGENERAL_gameOver_OutHigh,
        output SC_STATEMACHINEGENERAL_win_OutHigh,
        output SC_STATEMACHINEGENERAL_lives_Out,
        output SC_STATEMACHINEGENERAL_level_Out
    );

endinterface

// File: rtl/sc_updown_counter.sv
// Loadable up/down counter that saturates at 0 and at all-ones; load wins over inc/dec.
module sc_updown_counter #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic             SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= loadValue;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sc_game_controller.sv
// Frogger game sequencer: owns lives/level counters and drives registered Moore
// outputs to the background and frog datapaths.
module sc_game_controller
    import sc_game_pkg::*;
#(
    parameter int NUM_LIVES   = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int LIVES_W     = 2,
    parameter int LEVEL_W     = 2,
    parameter int CONTINUE_EN = 0
) (
    input  logic                 SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic                 SC_STATEMACHINEGENERAL_RESET_InHigh,
    sc_game_controller_if.slave  ctrlBus
);

    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(NUM_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

    gameState_t         state;
    gameState_t         nextState;
    logic               startPrev;
    logic               startPress;
    logic               livesLoad;
    logic               livesDec;
    logic               levelLoad;
    logic               levelInc;
    logic [LIVES_W-1:0] livesCount;
    logic [LEVEL_W-1:0] levelCount;

    assign startPress = startPrev & ~ctrlBus.SC_STATEMACHINEGENERAL_startButton_InLow;

    sc_updown_counter #(.WIDTH(LIVES_W), .RESET_VAL(LIVES_FULL)) livesCounter (
        .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
        .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
        .load                                (livesLoad),
        .loadValue                           (LIVES_FULL),
        .inc                                 (1'b0),
        .dec                                 (livesDec),
        .count                               (livesCount)
    );

    sc_updown_counter #(.WIDTH(LEVEL_W), .RESET_VAL('0)) levelCounter (
        .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
        .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
        .load                                (levelLoad),
        .loadValue                           ('0),
        .inc                                 (levelInc),
        .dec                                 (1'b0),
        .count                               (levelCount)
    );

    // Next-state and counter-control logic
    always_comb begin
        nextState = state;
        livesLoad = 1'b0;
        livesDec  = 1'b0;
        levelLoad = 1'b0;
        levelInc  = 1'b0;
        case (state)
            ST_RESET: begin
                livesLoad = 1'b1;
                levelLoad = 1'b1;
                nextState = ST_IDLE;
            end
            ST_IDLE: begin
                if (startPress) nextState = ST_PLAY;
            end
            ST_PLAY: begin
                // Collision outranks goal when both detectors fire together.
                if (ctrlBus.SC_STATEMACHINEGENERAL_Losing_InLow == ACTIVE_LOW_ON)
                    nextState = ST_HIT;
                else if (ctrlBus.SC_STATEMACHINEGENERAL_Goal_InLow == ACTIVE_LOW_ON)
                    nextState = ST_GOAL;
            end
            ST_HIT: begin
                livesDec  = 1'b1;
                nextState = (livesCount == LIVES_W'(1)) ? ST_GAME_OVER : ST_RESPAWN;
            end
            ST_GOAL: begin
                if (levelCount == LEVEL_LAST) begin
                    nextState = ST_WIN;
                end else begin
                    levelInc  = 1'b1;
                    nextState = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                // Held until both detectors release so a level-held input counts once.
                if ((ctrlBus.SC_STATEMACHINEGENERAL_Losing_InLow == ACTIVE_LOW_OFF) &&
                    (ctrlBus.SC_STATEMACHINEGENERAL_Goal_InLow == ACTIVE_LOW_OFF))
                    nextState = ST_PLAY;
            end
            ST_GAME_OVER: begin
                if (startPress) begin
                    if (CONTINUE_EN != 0) begin
                        livesLoad = 1'b1;
                        nextState = ST_RESPAWN;
                    end else begin
                        nextState = ST_RESET;
                    end
                end
            end
            ST_WIN: begin
                if (startPress) nextState = ST_RESET;
            end
            default: nextState = ST_RESET;
        endcase
    end

    // State and start-button edge registers
    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            state     <= ST_RESET;
            startPrev <= 1'b1;
        end else begin
            state     <= nextState;
            startPrev <= ctrlBus.SC_STATEMACHINEGENERAL_startButton_InLow;
        end
    end

    // Registered output decode, taken from the state being entered
    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            ctrlBus.SC_STATEMACHINEGENERAL_clear_OutLow     <= ACTIVE_LOW_ON;
            ctrlBus.SC_STATEMACHINEGENERAL_frogReset_OutLow <= ACTIVE_LOW_ON;
            ctrlBus.SC_STATEMACHINEGENERAL_levelUp_OutHigh  <= 1'b0;
            ctrlBus.SC_STATEMACHINEGENERAL_playing_OutHigh  <= 1'b0;
            ctrlBus.SC_STATEMACHINEGENERAL_gameOver_OutHigh <= 1'b0;
            ctrlBus.SC_STATEMACHINEGENERAL_win_OutHigh      <= 1'b0;
        end else begin
            ctrlBus.SC_STATEMACHINEGENERAL_clear_OutLow     <= (nextState == ST_RESET) ? ACTIVE_LOW_ON : ACTIVE_LOW_OFF;
            ctrlBus.SC_STATEMACHINEGENERAL_frogReset_OutLow <= ((nextState == ST_RESET) || (nextState == ST_RESPAWN)) ?
                                                               ACTIVE_LOW_ON : ACTIVE_LOW_OFF;
            // Level is stable across PLAY->GOAL, so it predicts whether GOAL will increment.
            ctrlBus.SC_STATEMACHINEGENERAL_levelUp_OutHigh  <= (nextState == ST_GOAL) && (levelCount != LEVEL_LAST);
            ctrlBus.SC_STATEMACHINEGENERAL_playing_OutHigh  <= (nextState == ST_PLAY);
            ctrlBus.SC_STATEMACHINEGENERAL_gameOver_OutHigh <= (nextState == ST_GAME_OVER);
            ctrlBus.SC_STATEMACHINEGENERAL_win_OutHigh      <= (nextState == ST_WIN);
        end
    end

    assign ctrlBus.SC_STATEMACHINEGENERAL_lives_Out = livesCount;
    assign ctrlBus.SC_STATEMACHINEGENERAL_level_Out = levelCount;

endmodule

// File: tb/tb_sc_game_controller.sv
// Scoreboard bench: three controller configurations share one stimulus stream and are
// checked every cycle against a game-rule reference model.
module tb_sc_game_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic los = 1'b1;
    logic gol = 1'b1;

    always #5 clk = ~clk;

    sc_game_controller_if #(.LIVES_W(2), .LEVEL_W(2)) busA ();
    sc_game_controller_if #(.LIVES_W(2), .LEVEL_W(2)) busB ();
    sc_game_controller_if #(.LIVES_W(2), .LEVEL_W(2)) busC ();

    assign busA.SC_STATEMACHINEGENERAL_startButton_InLow = btn;
    assign busA.SC_STATEMACHINEGENERAL_Losing_InLow      = los;
    assign busA.SC_STATEMACHINEGENERAL_Goal_InLow        = gol;
    assign busB.SC_STATEMACHINEGENERAL_startButton_InLow = btn;
    assign busB.SC_STATEMACHINEGENERAL_Losing_InLow      = los;
    assign busB.SC_STATEMACHINEGENERAL_Goal_InLow        = gol;
    assign busC.SC_STATEMACHINEGENERAL_startButton_InLow = btn;
    assign busC.SC_STATEMACHINEGENERAL_Losing_InLow      = los;
    assign busC.SC_STATEMACHINEGENERAL_Goal_InLow        = gol;

    sc_game_controller #(.NUM_LIVES(3), .NUM_LEVELS(4), .LIVES_W(2), .LEVEL_W(2), .CONTINUE_EN(0)) dutA (
        .SC_STATEMACHINEGENERAL_CLOCK_50     (clk),
        .SC_STATEMACHINEGENERAL_RESET_InHigh (rst),
        .ctrlBus                             (busA)
    );
    sc_game_controller #(.NUM_LIVES(3), .NUM_LEVELS(2), .LIVES_W(2), .LEVEL_W(2), .CONTINUE_EN(0)) dutB (
        .SC_STATEMACHINEGENERAL_CLOCK_50     (clk),
        .SC_STATEMACHINEGENERAL_RESET_InHigh (rst),
        .ctrlBus                             (busB)
    );
    sc_game_controller #(.NUM_LIVES(3), .NUM_LEVELS(4), .LIVES_W(2), .LEVEL_W(2), .CONTINUE_EN(1)) dutC (
        .SC_STATEMACHINEGENERAL_CLOCK_50     (clk),
        .SC_STATEMACHINEGENERAL_RESET_InHigh (rst),
        .ctrlBus                             (busC)
    );

    // {clear, frogReset, levelUp, playing, gameOver, win, lives[1:0], level[1:0]}
    logic [9:0] dutOut [3];
    assign dutOut[0] = {busA.SC_STATEMACHINEGENERAL_clear_OutLow, busA.SC_STATEMACHINEGENERAL_frogReset_OutLow, busA.SC_STATEMACHINEGENERAL_levelUp_OutHigh, busA.SC_STATEMACHINEGENERAL_playing_OutHigh, busA.SC_STATEMACHINEGENERAL_gameOver_OutHigh, busA.SC_STATEMACHINEGENERAL_win_OutHigh, busA.SC_STATEMACHINEGENERAL_lives_Out, busA.SC_STATEMACHINEGENERAL_level_Out};
    assign dutOut[1] = {busB.SC_STATEMACHINEGENERAL_clear_OutLow, busB.SC_STATEMACHINEGENERAL_frogReset_OutLow, busB.SC_STATEMACHINEGENERAL_levelUp_OutHigh, busB.SC_STATEMACHINEGENERAL_playing_OutHigh, busB.SC_STATEMACHINEGENERAL_gameOver_OutHigh, busB.SC_STATEMACHINEGENERAL_win_OutHigh, busB.SC_STATEMACHINEGENERAL_lives_Out, busB.SC_STATEMACHINEGENERAL_level_Out};
    assign dutOut[2] = {busC.SC_STATEMACHINEGENERAL_clear_OutLow, busC.SC_STATEMACHINEGENERAL_frogReset_OutLow, busC.SC_STATEMACHINEGENERAL_levelUp_OutHigh, busC.SC_STATEMACHINEGENERAL_playing_OutHigh, busC.SC_STATEMACHINEGENERAL_gameOver_OutHigh, busC.SC_STATEMACHINEGENERAL_win_OutHigh, busC.SC_STATEMACHINEGENERAL_lives_Out, busC.SC_STATEMACHINEGENERAL_level_Out};

    // Reference model: game phase plus plain integer lives/level per configuration
    localparam int PH_RESET   = 0;
    localparam int PH_IDLE    = 1;
    localparam int PH_PLAY    = 2;
    localparam int PH_HIT     = 3;
    localparam int PH_GOAL    = 4;
    localparam int PH_RESPAWN = 5;
    localparam int PH_OVER    = 6;
    localparam int PH_WIN     = 7;

    int cfgLives  [3] = '{3, 3, 3};
    int cfgLevels [3] = '{4, 2, 4};
    int cfgCont   [3] = '{0, 0, 1};

    int phase  [3];
    int mLives [3];
    int mLevel [3];
    bit mPrev  [3];

    int tests = 0;
    int fails = 0;
    int levelUpSeenA = 0;
    logic [29:0] sbq [$];

    task automatic modelEdge(input logic b, input logic l, input logic g, input logic r);
        bit press;
        for (int c = 0; c < 3; c++) begin
            if (r) begin
                phase[c]  = PH_RESET;
                mLives[c] = cfgLives[c];
                mLevel[c] = 0;
                mPrev[c]  = 1'b1;
            end else begin
                press    = mPrev[c] && !b;
                mPrev[c] = b;
                case (phase[c])
                    PH_RESET: begin
                        mLives[c] = cfgLives[c];
                        mLevel[c] = 0;
                        phase[c]  = PH_IDLE;
                    end
                    PH_IDLE: if (press) phase[c] = PH_PLAY;
                    PH_PLAY: begin
                        if (!l)      phase[c] = PH_HIT;
                        else if (!g) phase[c] = PH_GOAL;
                    end
                    PH_HIT: begin
                        phase[c]  = (mLives[c] == 1) ? PH_OVER : PH_RESPAWN;
                        mLives[c] = (mLives[c] > 0) ? mLives[c] - 1 : 0;
                    end
                    PH_GOAL: begin
                        if (mLevel[c] == cfgLevels[c] - 1) begin
                            phase[c] = PH_WIN;
                        end else begin
                            mLevel[c] = mLevel[c] + 1;
                            phase[c]  = PH_RESPAWN;
                        end
                    end
                    PH_RESPAWN: if (l && g) phase[c] = PH_PLAY;
                    PH_OVER: begin
                        if (press) begin
                            if (cfgCont[c] != 0) begin
                                mLives[c] = cfgLives[c];
                                phase[c]  = PH_RESPAWN;
                            end else begin
                                phase[c] = PH_RESET;
                            end
                        end
                    end
                    default: if (press) phase[c] = PH_RESET;
                endcase
            end
        end
    endtask

    function automatic logic [9:0] expVec(input int c);
        logic inGoalUp;
        inGoalUp = (phase[c] == PH_GOAL) && (mLevel[c] != cfgLevels[c] - 1);
        return {phase[c] != PH_RESET, !((phase[c] == PH_RESET) || (phase[c] == PH_RESPAWN)), inGoalUp,
                phase[c] == PH_PLAY, phase[c] == PH_OVER, phase[c] == PH_WIN, 2'(mLives[c]), 2'(mLevel[c])};
    endfunction

    // Drive inputs mid-cycle, predict the outputs after the next edge, queue them.
    task automatic step(input logic b, input logic l, input logic g, input logic r);
        @(posedge clk);
        #4;
        btn = b; los = l; gol = g; rst = r;
        modelEdge(b, l, g, r);
        sbq.push_back({expVec(0), expVec(1), expVec(2)});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic press();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic spot(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every cycle each configuration presents outputs; compare against the queue.
    initial begin
        logic [29:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (busA.SC_STATEMACHINEGENERAL_levelUp_OutHigh) levelUpSeenA++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                for (int c = 0; c < 3; c++) begin
                    tests++;
                    if (dutOut[c] !== e[29-10*c -: 10]) begin
                        fails++;
                        $display("FAIL cfg%0d outputs: got %b, expected %b at %0t", c, dutOut[c], e[29-10*c -: 10], $time);
                    end
                end
            end
        end
    end

    initial begin
        modelEdge(1'b0, 1'b1, 1'b1, 1'b1);

        // Button held low through reset and after release: no press
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        spot("no_play_while_held", int'(busA.SC_STATEMACHINEGENERAL_playing_OutHigh), 0);
        idle(2);
        press();
        spot("playing_after_press", int'(busA.SC_STATEMACHINEGENERAL_playing_OutHigh), 1);

        // Three hits with release between each
        repeat (3) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            idle(3);
        end
        spot("gameover_after_3_hits", int'(busA.SC_STATEMACHINEGENERAL_gameOver_OutHigh), 1);
        spot("lives_zero", int'(busA.SC_STATEMACHINEGENERAL_lives_Out), 0);
        press();
        press();

        // Goal held for five cycles
        levelUpSeenA = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        spot("single_levelup", levelUpSeenA, 1);
        spot("level_after_goal", int'(busA.SC_STATEMACHINEGENERAL_level_Out), 1);

        // Losing and goal in the same cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        spot("both_low_level", int'(busA.SC_STATEMACHINEGENERAL_level_Out), 1);
        spot("both_low_lives", int'(busA.SC_STATEMACHINEGENERAL_lives_Out), 2);

        // Second goal: two-level configuration wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        spot("win_flag", int'(busB.SC_STATEMACHINEGENERAL_win_OutHigh), 1);
        spot("win_level", int'(busB.SC_STATEMACHINEGENERAL_level_Out), 1);
        press();
        spot("restart_lives", int'(busB.SC_STATEMACHINEGENERAL_lives_Out), 3);
        spot("restart_level", int'(busB.SC_STATEMACHINEGENERAL_level_Out), 0);

        // Continue configuration: game over at level 2, then continue
        repeat (2) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            idle(3);
        end
        spot("cont_gameover", int'(busC.SC_STATEMACHINEGENERAL_gameOver_OutHigh), 1);
        spot("cont_level_before", int'(busC.SC_STATEMACHINEGENERAL_level_Out), 2);
        press();
        spot("cont_lives", int'(busC.SC_STATEMACHINEGENERAL_lives_Out), 3);
        spot("cont_level_kept", int'(busC.SC_STATEMACHINEGENERAL_level_Out), 2);
        spot("cont_playing", int'(busC.SC_STATEMACHINEGENERAL_playing_OutHigh), 1);

        // Randomised play
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 5) != 0, $urandom_range(0, 11) != 0,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0);
        end

        // Async reset in the middle of PLAY
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);
        press();
        spot("pre_reset_playing", int'(busA.SC_STATEMACHINEGENERAL_playing_OutHigh), 1);
        @(posedge clk);
        #4;
        btn = 1'b1; los = 1'b1; gol = 1'b1; rst = 1'b1;
        modelEdge(1'b1, 1'b1, 1'b1, 1'b1);
        sbq.push_back({expVec(0), expVec(1), expVec(2)});
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (dutOut[c] !== 10'b00_0000_11_00) begin
                fails++;
                $display("FAIL async_reset cfg%0d: got %b, expected %b", c, dutOut[c], 10'b00_0000_11_00);
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        idle(4);

        repeat (3) @(posedge clk);
        #3;
        spot("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
